// File: rtl/nonce_dispenser.sv
// Round-robin nonce dispenser: one shared counter hands consecutive nonces from a loaded
// [base, limit] range to NREQ requesting lanes, one registered grant per cycle.
module nonce_dispenser #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NREQ      = 4,
    parameter int unsigned IDW       = 2,
    parameter int unsigned INCREMENT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] limit,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  grant,
    output logic             grant_valid,
    output logic [IDW-1:0]   grant_id,
    output logic [WIDTH-1:0] nonce,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic [WIDTH-1:0] nonce_q, nonce_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic             grant_valid_q, grant_valid_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   pick;
    logic             pick_found;
    logic [31:0]      idx;
    logic             done_q;
    logic             cnt_load, cnt_inc;
    logic [WIDTH:0]   sum;
    logic             exhausted;

    // One extra bit on the sum so a wrap past all-ones counts as exhaustion.
    assign sum       = {1'b0, count_q} + (WIDTH + 1)'(INCREMENT);
    assign exhausted = sum[WIDTH] | (sum[WIDTH-1:0] > lim_q);

    // Counter datapath: load takes priority over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (cnt_load) begin
            count_q <= base;
        end else if (cnt_inc) begin
            count_q <= sum[WIDTH-1:0];
        end
    end

    // First requesting lane at or after the round-robin pointer.
    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        idx        = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (32'(ptr_q) + 32'(i)) % NREQ;
            if (!pick_found && req[idx[IDW-1:0]]) begin
                pick_found = 1'b1;
                pick       = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        lim_d         = lim_q;
        ptr_d         = ptr_q;
        grant_d       = '0;
        grant_valid_d = 1'b0;
        grant_id_d    = grant_id_q;
        nonce_d       = nonce_q;
        cnt_load      = 1'b0;
        cnt_inc       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_load = 1'b1;
                    lim_d    = limit;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StDone;
                end else if (pick_found) begin
                    grant_d[pick] = 1'b1;
                    grant_valid_d = 1'b1;
                    grant_id_d    = pick;
                    nonce_d       = count_q;
                    cnt_inc       = 1'b1;
                    ptr_d         = (32'(pick) == NREQ - 1) ? '0 : pick + 1'b1;
                    if (exhausted) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            lim_q         <= '0;
            ptr_q         <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            nonce_q       <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            lim_q         <= lim_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            nonce_q       <= nonce_d;
            done_q        <= (state_q == StDone);
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign nonce       = nonce_q;
    assign busy        = (state_q == StRun);
    assign done        = done_q;

endmodule
